// File: rtl/sipo_collector.sv
// sipo_collector: serial-in / parallel-out frame collector.
//
// Accepts BIT-wide words over a valid/ready handshake and assembles them into
// NDATA-word frames. The first word received lands in o_data[0]. A completed
// frame is held stable with o_valid until the consumer takes it (i_ready).
//
// Optional feature macro: SIPO_FLUSH_EN
//   When defined, the i_flush port closes a partial frame early. Unused slots
//   are filled with PAD, and o_count reports the number of real words.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid/o_ready/i_data   upstream word handshake
//   o_valid/i_ready/o_data   downstream frame handshake; o_data[0] = first word
//   o_count        number of words currently held (0..NDATA)
//   i_flush        close the partial frame (SIPO_FLUSH_EN only)
module sipo_collector #(
  parameter int BIT = 8,
  parameter int NDATA = 3,
  parameter logic [BIT-1:0] PAD = '0,
  localparam int CW = $clog2(NDATA + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [BIT-1:0] i_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [BIT-1:0] o_data [0:NDATA-1],
`ifdef SIPO_FLUSH_EN
  input  logic           i_flush,
`endif
  output logic [CW-1:0]  o_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [BIT-1:0] r_buf [0:NDATA-1];

  logic           w_word_acc;
  logic           w_frame_acc;
  logic           w_flush;
  logic [CW-1:0]  w_next_cnt;

`ifdef SIPO_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // In HOLD the upstream may only push a word in the same cycle the frame
  // leaves, so ready passes straight through from the consumer.
  assign o_ready     = !i_rst && ((r_state == FILL) || i_ready);
  assign w_word_acc  = i_valid && o_ready;
  assign w_frame_acc = (r_state == HOLD) && i_ready;

  // Word count after this cycle's accept while filling.
  assign w_next_cnt  = w_word_acc ? (r_cnt + CW'(1)) : r_cnt;

  assign o_valid = (r_state == HOLD);
  assign o_count = r_cnt;
  assign o_data  = r_buf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      for (int i = 0; i < NDATA; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_word_acc) r_buf[r_cnt] <= i_data;
          if (w_word_acc && (r_cnt == CW'(NDATA - 1))) begin
            r_state <= HOLD;
            r_cnt   <= CW'(NDATA);
          end else if (w_flush && (w_next_cnt != '0)) begin
            // Slots past the last real word get PAD; the real word (if any)
            // sits at r_cnt, which is below w_next_cnt, so writes never overlap.
            for (int i = 0; i < NDATA; i++) begin
              if (i >= int'(w_next_cnt)) r_buf[i] <= PAD;
            end
            r_state <= HOLD;
            r_cnt   <= w_next_cnt;
          end else begin
            r_cnt <= w_next_cnt;
          end
        end
        HOLD: begin
          if (w_frame_acc) begin
            if (w_word_acc) begin
              // Frame leaves and the next frame's first word enters together.
              r_buf[0] <= i_data;
              r_cnt    <= CW'(1);
              r_state  <= (NDATA == 1) ? HOLD : FILL;
            end else begin
              r_cnt   <= '0;
              r_state <= FILL;
            end
          end
        end
        default: begin
          r_state <= FILL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_collector.sv
module tb_sipo_collector;

  localparam int BIT = 8;
  localparam int NDATA = 3;

  logic           clk;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  logic [BIT-1:0] i_data;
  logic           o_valid;
  logic           i_ready;
  logic [BIT-1:0] o_data [0:NDATA-1];
  logic [1:0]     o_count;
`ifdef SIPO_FLUSH_EN
  logic           i_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  sipo_collector #(.BIT(BIT), .NDATA(NDATA), .PAD(8'hFF)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
`ifdef SIPO_FLUSH_EN
    .i_flush (i_flush),
`endif
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frm(input int c, input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] d);
    return {8'(c), a, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  // Monitor: every frame handed downstream is compared with the scoreboard.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL frame_unexpected: got %h expected none",
                 {6'd0, o_count, o_data[0], o_data[1], o_data[2]});
      end else begin
        chk("frame", {6'd0, o_count, o_data[0], o_data[1], o_data[2]}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'h99; i_ready = 1'b0;
`ifdef SIPO_FLUSH_EN
    i_flush = 1'b0;
`endif
    // Reset held two cycles with valid asserted.
    tick();
    tick();
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_count", {30'd0, o_count}, 32'd0);
    chk("rst_data", {8'd0, o_data[0], o_data[1], o_data[2]}, 32'd0);
    i_rst = 1'b0; i_valid = 1'b0;
    tick();
    chk("idle_count", {30'd0, o_count}, 32'd0);

    // Basic frame with the consumer stalled.
    exp_q.push_back(frm(3, 8'h11, 8'h22, 8'h33));
    send(8'h11);
    chk("basic_cnt1", {30'd0, o_count}, 32'd1);
    chk("basic_d0", {24'd0, o_data[0]}, 32'h11);
    send(8'h22);
    chk("basic_valid_early", {31'd0, o_valid}, 32'd0);
    send(8'h33);
    chk("basic_valid", {31'd0, o_valid}, 32'd1);
    chk("basic_count", {30'd0, o_count}, 32'd3);
    chk("basic_ready", {31'd0, o_ready}, 32'd0);
    tick();
    tick();
    chk("basic_hold", {31'd0, o_valid}, 32'd1);
    i_ready = 1'b1;
    tick();
    chk("basic_release", {31'd0, o_valid}, 32'd0);
    chk("basic_cnt0", {30'd0, o_count}, 32'd0);

    // Back-to-back frames, consumer always ready.
    exp_q.push_back(frm(3, 8'h01, 8'h02, 8'h03));
    exp_q.push_back(frm(3, 8'h04, 8'h05, 8'h06));
    for (int k = 1; k <= 6; k++) begin
      i_valid = 1'b1;
      i_data  = 8'(k);
      #1;
      chk("b2b_ready", {31'd0, o_ready}, 32'd1);
      tick();
      chk("b2b_valid", {31'd0, o_valid}, {31'd0, (k % 3) == 0});
    end
    i_valid = 1'b0;
    tick();
    chk("b2b_done", {31'd0, o_valid}, 32'd0);

    // Stall in HOLD with a pending word, then resume.
    i_ready = 1'b0;
    exp_q.push_back(frm(3, 8'h31, 8'h32, 8'h33));
    send(8'h31);
    send(8'h32);
    send(8'h33);
    i_valid = 1'b1;
    i_data  = 8'hAA;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready", {31'd0, o_ready}, 32'd0);
      chk("stall_data", {6'd0, o_count, o_data[0], o_data[1], o_data[2]},
          frm(3, 8'h31, 8'h32, 8'h33));
      tick();
    end
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("resume_count", {30'd0, o_count}, 32'd1);
    chk("resume_d0", {24'd0, o_data[0]}, 32'hAA);
    chk("resume_valid", {31'd0, o_valid}, 32'd0);
    exp_q.push_back(frm(3, 8'hAA, 8'hBB, 8'hCC));
    send(8'hBB);
    send(8'hCC);
    tick();

    // Reset mid-frame discards partial words.
    send(8'h11);
    send(8'h22);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_count", {30'd0, o_count}, 32'd0);
    exp_q.push_back(frm(3, 8'h44, 8'h55, 8'h66));
    send(8'h44);
    send(8'h55);
    send(8'h66);
    tick();

`ifdef SIPO_FLUSH_EN
    // Flush with nothing held is ignored.
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_empty_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_empty_count", {30'd0, o_count}, 32'd0);
    // Flush together with the second word.
    i_ready = 1'b0;
    exp_q.push_back(frm(2, 8'h10, 8'h20, 8'hFF));
    send(8'h10);
    i_flush = 1'b1;
    send(8'h20);
    i_flush = 1'b0;
    chk("flush_valid", {31'd0, o_valid}, 32'd1);
    chk("flush_count", {30'd0, o_count}, 32'd2);
    i_ready = 1'b1;
    tick();
`endif

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_collector.md
# sipo_collector

Serial-in / parallel-out collector that accepts a stream of BIT-wide words over a valid/ready handshake and assembles them into NDATA-word frames. It is the receive-side counterpart of the parallel-load shift-out stage: word order is preserved so the first word received lands in index 0, and a frame shifted out by that stage round-trips unchanged. A completed frame is held stable with o_valid until the downstream consumer accepts it.

## Interface
- BIT, 8, width of one word
- NDATA, 3, words per frame (>= 1)
- PAD, 0, fill value for unreceived slots of a flushed frame
- CW, $clog2(NDATA+1), width of o_count (derived, not overridden)

- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  upstream word valid
- o_ready  out  1  block accepts a word this cycle
- i_data  in  BIT  upstream word
- o_valid  out  1  completed frame available
- i_ready  in  1  downstream accepts frame this cycle
- o_data  out  [BIT-1:0] x [0:NDATA-1]  frame buffer, unpacked array, index 0 = first word
- o_count  out  CW  words held in buffer
- i_flush  in  1  close partial frame (only with SIPO_FLUSH_EN)

## Operation
- Word accept: i_valid && o_ready. Frame accept: o_valid && i_ready.
- States: FILL, HOLD. Internal counter cnt (0..NDATA).
- FILL: o_ready=1, o_valid=0. On word accept: buf[cnt] <= i_data, cnt <= cnt+1. If cnt was NDATA-1 → HOLD, cnt = NDATA.
- HOLD: o_valid=1, o_ready=i_ready (combinational pass-through). Buffer and o_count frozen.
- HOLD with frame accept and no word accept → FILL, cnt=0.
- HOLD with frame accept and word accept same cycle → buf[0] <= i_data, cnt=1, FILL (for NDATA=1: stay HOLD, cnt=1). No bubble.
- Word accept without frame accept in HOLD cannot occur (o_ready=0).
- Slots not written in the current frame keep prior contents; o_data is only meaningful while o_valid=1.
- o_count = cnt at all times.
- NDATA=1: every word accept goes directly to HOLD.
- Upstream must hold i_data/i_valid stable until accepted; downstream may sample o_data any cycle o_valid=1.

## Timing
- Reset (i_rst=1 at a clock edge): state FILL, cnt=0, all buffer slots 0, o_valid=0, o_count=0. o_ready=0 while i_rst is high.
- Reset mid-frame or in HOLD discards all held words; no frame is emitted.
- Word accepted in cycle t is visible in o_data at t+1.
- Last word of a frame accepted in cycle t → o_valid=1 at t+1.
- Sustained throughput: NDATA words per NDATA cycles when downstream holds i_ready=1.
- o_ready in HOLD depends combinationally on i_ready; o_valid and o_data are registered.

## Configuration
- SIPO_FLUSH_EN defined: i_flush port present. In FILL, i_flush=1 with cnt>0 or a word accept that cycle closes the frame: the accepted word (if any) is written to slot cnt first, all remaining slots up to NDATA-1 written with PAD, state → HOLD, cnt/o_count = number of real words (1..NDATA). i_flush with cnt=0 and no word accept: ignored. i_flush in HOLD: ignored. Flush coinciding with the frame-completing word behaves as a normal frame (o_count=NDATA).
- SIPO_FLUSH_EN undefined: i_flush port absent; behaviour identical to i_flush tied 0.

## Test plan
- Reset: assert i_rst 2 cycles with i_valid=1 → o_ready=0, o_valid=0, o_count=0, o_data={0,0,0}.
- Basic frame: i_ready=0, send 0x11,0x22,0x33 on consecutive cycles → o_valid=1 one cycle after 0x33, o_data={0x11,0x22,0x33}, o_count=3, o_ready=0 until i_ready.
- Back-to-back: i_ready=1, i_valid=1 continuously with 0x01..0x06 → frames {0x01,0x02,0x03} and {0x04,0x05,0x06}, each o_valid for exactly 1 cycle, no idle cycle on o_ready.
- Stall and resume: hold i_ready=0 for 5 cycles in HOLD while i_valid=1 with 0xAA → o_data unchanged, 0xAA accepted in the cycle i_ready rises, lands in o_data[0], o_count=1.
- Reset mid-frame: accept 0x11,0x22, pulse i_rst, then send 0x44,0x55,0x66 → only frame {0x44,0x55,0x66} emitted.
- Flush (SIPO_FLUSH_EN, PAD=0xFF): accept 0x10, next cycle i_flush=1 with i_valid=1, i_data=0x20 → o_data={0x10,0x20,0xFF}, o_count=2, o_valid=1.
